sum_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter that sits directly downstream of the 8-bit ripple adder and consumes its 9-bit sum (0..510).
- Uses shift-and-add-3 (double-dabble), one bit per clock.
- Produces three packed BCD digits for the board's hex-display driver.
- Uses a start/busy/done handshake, so the adder output is sampled once per request and need not be held.

---
 rtl/sum_bcd_pkg.sv | 35 +++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/sum_bcd_converter.sv | 112 +++++++++++
 tb/tb_sum_bcd_converter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum_bcd_converter: FSM encoding, digit
// arithmetic constants and active-low seven-segment patterns (bit order g..a).
package sum_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int          DIGIT_W     = 4;
  localparam logic [3:0]  ADD3_THRESH = 4'd5;
  localparam logic [3:0]  ADD3_INC    = 4'd3;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Used at elaboration to prove the scratch register cannot overflow.
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low seven-segment pattern (bit order g..a).
// Codes 10-15 are never produced upstream and decode to blank.
module bcd_to_seg7
  import sum_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter for the adder sum, one bit
// per clock, start/busy/done handshake. Define SUM_BCD_SEG_EN for a seg output.
module sum_bcd_converter
  import sum_bcd_pkg::*;
#(
  parameter int WIDTH  = 9,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd
`ifdef SUM_BCD_SEG_EN
  ,
  output logic [7*DIGITS-1:0]     seg
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = DIGIT_W * DIGITS;

  // Handshake: start is sampled only while idle (busy=0); requests while busy are
  // dropped. done is a one-cycle pulse coinciding with the update of bcd.

  if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_bad_params
    $error("sum_bcd_converter: DIGITS too small to hold 2^WIDTH-1");
  end

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic [SW-1:0]     scratch, scratch_nxt, scratch_adj;
  logic [CW-1:0]     count, count_nxt;
  logic              busy_nxt, done_nxt;
  logic [SW-1:0]     bcd_nxt;

  // Add-3 correction per digit, no carry between digits.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[d*DIGIT_W +: DIGIT_W] >= ADD3_THRESH)
        scratch_adj[d*DIGIT_W +: DIGIT_W] = scratch[d*DIGIT_W +: DIGIT_W] + ADD3_INC;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    scratch_nxt = scratch;
    count_nxt   = count;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    bcd_nxt     = bcd;
    case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt   = bin;
          scratch_nxt = '0;
          count_nxt   = CW'(WIDTH);
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_nxt, shreg_nxt} = {scratch_adj, shreg} << 1;
        count_nxt = count - CW'(1);
        if (count == CW'(1)) state_nxt = FINISH;
      end
      FINISH: begin
        bcd_nxt   = scratch;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      scratch <= scratch_nxt;
      count   <= count_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bcd     <= bcd_nxt;
    end
  end

`ifdef SUM_BCD_SEG_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_to_seg7 u_seg (
      .digit (bcd[g*DIGIT_W +: DIGIT_W]),
      .seg   (seg[g*7 +: 7])
    );
  end
`else
  // Display decoding lives downstream when the segment option is off.
`endif

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Self-checking bench for sum_bcd_converter: directed and random conversions
// against a decimal-arithmetic model, plus reset, overlap and streaming cases.
module tb_sum_bcd_converter;

  localparam int WIDTH  = 9;
  localparam int DIGITS = 3;
  localparam int MAXV   = 510;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  bin = '0;
  logic        busy, done;
  logic [11:0] bcd;
`ifdef SUM_BCD_SEG_EN
  logic [20:0] seg;
`endif

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  sum_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
`ifdef SUM_BCD_SEG_EN
    ,
    .seg    (seg)
`endif
  );

  // reference model: decimal digits by plain division
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[11:8] = 4'((v / 100) % 10);
    return r;
  endfunction

`ifdef SUM_BCD_SEG_EN
  function automatic logic [20:0] to_seg(input logic [11:0] b);
    logic [6:0] tbl [10];
    logic [20:0] r;
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    r = '0;
    for (int d = 0; d < 3; d++) r[d*7 +: 7] = tbl[int'(b[d*4 +: 4])];
    return r;
  endfunction
`endif

  // scoreboard compare
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full conversion with latency, busy and result checks
  task automatic run_conv(input int v, input string tag);
    int lat;
    lat = -1;
    bin = 9'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    bin = 9'($urandom_range(0, MAXV));
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 14; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (n <= 9) check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(lat), 32'd10);
    check({tag, "_bcd"}, 32'(bcd), 32'(to_bcd(v)));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef SUM_BCD_SEG_EN
    check({tag, "_seg"}, 32'(seg), 32'(to_seg(to_bcd(v))));
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, n_done, k, n_acc, next_acc, last_done;
    logic prev_done, saw_done;
    logic [11:0] cap;

    // reset state
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
`ifdef SUM_BCD_SEG_EN
    check("rst_seg", 32'(seg), 32'({3{7'b1000000}}));
`endif
    #2 resetn = 1'b1;
    tick();

    // directed values including both range ends
    run_conv(0, "v0");
    run_conv(510, "v510");
    run_conv(255, "v255");
    run_conv(99, "v99");
    run_conv(100, "v100");
    run_conv(408, "v408");
    check("v408_fixed", 32'(bcd), 32'h408);
`ifdef SUM_BCD_SEG_EN
    check("v408_seg_fixed", 32'(seg), 32'({7'b0011001, 7'b1000000, 7'b0000000}));
`endif

    // second start during busy is ignored
    bin = 9'd37;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1;
    bin = 9'd400;
    tick();
    start = 1'b0;
    lat = -1;
    n_done = 0;
    cap = '0;
    for (int e = 5; e <= 24; e++) begin
      tick();
      if (done === 1'b1) begin
        n_done++;
        if (lat < 0) begin
          lat = e;
          cap = bcd;
        end
      end
    end
    check("ovl_latency", 32'(lat), 32'd10);
    check("ovl_bcd", 32'(cap), 32'h037);
    check("ovl_ndone", 32'(n_done), 32'd1);

    // asynchronous reset mid-conversion
    bin = 9'd123;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
`ifdef SUM_BCD_SEG_EN
    check("mid_rst_seg", 32'(seg), 32'({3{7'b1000000}}));
`endif
    saw_done = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    resetn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    run_conv(321, "v321");

    // random conversions
    for (int i = 0; i < 24; i++) run_conv(int'($urandom_range(0, MAXV)), "rnd");

    // start held high, bin stepping each cycle; accepts every WIDTH+2 edges
    k = int'($urandom_range(0, MAXV));
    n_acc = 0;
    next_acc = 0;
    last_done = -1;
    prev_done = 1'b0;
    start = 1'b1;
    bin = 9'(k);
    for (int c = 0; c < 511 * 11 + 12; c++) begin
      if (n_acc < 511 && c == next_acc) begin
        exp_q.push_back(to_bcd(int'(bin)));
        n_acc++;
        next_acc += 11;
      end
      tick();
      if (n_acc == 511) start = 1'b0;
      if (done === 1'b1) begin
        check("cont_back2back", 32'(prev_done), 32'd0);
        if (last_done >= 0) check("cont_gap", 32'(c - last_done), 32'd11);
        last_done = c;
        if (exp_q.size() > 0) check("cont_bcd", 32'(bcd), 32'(exp_q.pop_front()));
        else check("cont_extra_done", 32'(done), 32'd0);
      end
      prev_done = done;
      k = (k + 1) % 511;
      bin = 9'(k);
    end
    check("cont_drain", 32'(exp_q.size()), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
